// File: rtl/lfsr_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_share_ctrl
// Brief    : Seeds one external LFSR, discards a warm-up run, then shares its
//            output one word per clock among NREQ round-robin requesters.
//            Optional macro LFSR_SHARE_ZERO_GUARD_EN adds an all-zero guard.
// Revision : 1.0  initial release
// ============================================================================
module lfsr_share_ctrl #(
    parameter int               NREQ   = 4,
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] SEED   = 32'h1232_4a6f,
    parameter int               WARMUP = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [WIDTH-1:0] data,
    output logic             data_valid,
    input  logic             reseed_req,
    input  logic [WIDTH-1:0] reseed_seed,
    output logic             busy,
    input  logic [WIDTH-1:0] lfsr_num,
    output logic [WIDTH-1:0] lfsr_seed,
    output logic             lfsr_write,
    output logic             zero_err
);

    localparam int              IDXW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IDXW-1:0] LAST_RST = IDXW'(NREQ - 1);
    localparam logic [7:0]      CNT_INIT = 8'(WARMUP);

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_SERVE  = 2'd2
    } state_t;

    state_t           r_state, w_stateNext;
    logic [7:0]       r_cnt, w_cntNext;
    logic [WIDTH-1:0] r_seed, w_seedNext;
    logic [NREQ-1:0]  r_gnt, w_gntNext;
    logic [WIDTH-1:0] r_data, w_dataNext;
    logic             r_dataValid, w_validNext;
    logic [IDXW-1:0]  r_lastGrant, w_lastNext;

    logic             w_serve;
    logic             w_found;
    logic [IDXW-1:0]  w_pick;
    logic [IDXW-1:0]  w_cand;
    int               w_idx;

    // Round-robin search starting just above the last granted requester.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_lastGrant;
        w_idx   = 0;
        w_cand  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            w_idx  = (int'(r_lastGrant) + i) % NREQ;
            w_cand = IDXW'(w_idx);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

`ifdef LFSR_SHARE_ZERO_GUARD_EN
    logic r_zeroErr;
    logic w_zeroHit;
`endif

    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_seedNext  = r_seed;
        w_gntNext   = '0;
        w_validNext = 1'b0;
        w_dataNext  = r_data;
        w_lastNext  = r_lastGrant;
        w_serve     = 1'b0;
`ifdef LFSR_SHARE_ZERO_GUARD_EN
        w_zeroHit   = 1'b0;
`endif
        case (r_state)
            ST_SEED: begin
                w_stateNext = ST_WARMUP;
                w_cntNext   = CNT_INIT;
            end
            // The last warm-up cycle already serves, so the first grant and
            // the falling edge of busy land on the same clock edge.
            ST_WARMUP: begin
                if (r_cnt <= 8'd1) begin
                    w_stateNext = ST_SERVE;
                    w_serve     = 1'b1;
                end else begin
                    w_cntNext = r_cnt - 8'd1;
                end
            end
            ST_SERVE: w_serve = 1'b1;
            default:  w_stateNext = ST_SEED;
        endcase

`ifdef LFSR_SHARE_ZERO_GUARD_EN
        if (w_serve && (lfsr_num == '0)) begin
            w_zeroHit   = 1'b1;
            w_serve     = 1'b0;
            w_stateNext = ST_SEED;
            w_seedNext  = SEED;
        end
`endif

        if (w_serve && w_found) begin
            w_gntNext   = {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
            w_validNext = 1'b1;
            w_dataNext  = lfsr_num;
            w_lastNext  = w_pick;
        end

        // Reseed pre-empts any grant decided above.
        if (reseed_req) begin
            w_stateNext = ST_SEED;
            w_seedNext  = (reseed_seed == '0) ? SEED : reseed_seed;
            w_gntNext   = '0;
            w_validNext = 1'b0;
            w_dataNext  = r_data;
            w_lastNext  = r_lastGrant;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_SEED;
            r_cnt       <= CNT_INIT;
            r_seed      <= SEED;
            r_gnt       <= '0;
            r_data      <= '0;
            r_dataValid <= 1'b0;
            r_lastGrant <= LAST_RST;
        end else begin
            r_state     <= w_stateNext;
            r_cnt       <= w_cntNext;
            r_seed      <= w_seedNext;
            r_gnt       <= w_gntNext;
            r_data      <= w_dataNext;
            r_dataValid <= w_validNext;
            r_lastGrant <= w_lastNext;
        end
    end

`ifdef LFSR_SHARE_ZERO_GUARD_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_zeroErr <= 1'b0;
        end else if (w_zeroHit) begin
            r_zeroErr <= 1'b1;
        end
    end
    assign zero_err = r_zeroErr;
`else
    assign zero_err = 1'b0;
`endif

    assign gnt        = r_gnt;
    assign data       = r_data;
    assign data_valid = r_dataValid;
    assign busy       = (r_state != ST_SERVE);
    assign lfsr_write = (r_state == ST_SEED);
    assign lfsr_seed  = r_seed;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_share_ctrl
// Brief    : Directed scoreboard bench for lfsr_share_ctrl (NREQ=4, WARMUP=8).
// Revision : 1.0  initial release
// ============================================================================
module tb_lfsr_share_ctrl;

    localparam logic [31:0] DEF_SEED = 32'h1232_4a6f;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [31:0] data;
    logic        data_valid;
    logic        reseed_req;
    logic [31:0] reseed_seed;
    logic        busy;
    logic [31:0] lfsr_num;
    logic [31:0] lfsr_seed;
    logic        lfsr_write;
    logic        zero_err;

    lfsr_share_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .gnt         (gnt),
        .data        (data),
        .data_valid  (data_valid),
        .reseed_req  (reseed_req),
        .reseed_seed (reseed_seed),
        .busy        (busy),
        .lfsr_num    (lfsr_num),
        .lfsr_seed   (lfsr_seed),
        .lfsr_write  (lfsr_write),
        .zero_err    (zero_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          e;
        logic [3:0]  g;
        logic [31:0] d;
    } exp_t;

    exp_t        q[$];
    int          checks   = 0;
    int          failures = 0;
    int          edgeNo   = 0;
    logic [31:0] holdData = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every edge either matches the queued grant or must be idle.
    always @(posedge clk) begin : mon
        logic rs;
        exp_t x;
        rs = reset;
        edgeNo++;
        #2;
        if (rs) holdData = 32'h0;
        if (q.size() > 0 && q[0].e == edgeNo) begin
            x = q.pop_front();
            checks++;
            if (data_valid !== 1'b1 || gnt !== x.g || data !== x.d) begin
                failures++;
                $display("FAIL grant@%0d: gnt=%b valid=%b data=%h expected gnt=%b valid=1 data=%h",
                         edgeNo, gnt, data_valid, data, x.g, x.d);
            end
            holdData = x.d;
        end else begin
            checks++;
            if (data_valid !== 1'b0 || gnt !== 4'b0000 || data !== holdData) begin
                failures++;
                $display("FAIL idle@%0d: gnt=%b valid=%b data=%h expected gnt=0000 valid=0 data=%h",
                         edgeNo, gnt, data_valid, data, holdData);
            end
        end
    end

    task automatic step(input logic [3:0] r, input logic [3:0] eg, input logic rsq,
                        input logic [31:0] rsd, input logic zero);
        req         = r;
        reseed_req  = rsq;
        reseed_seed = rsd;
        lfsr_num    = zero ? 32'h0 : (32'hC0DE_0000 + 32'(edgeNo + 1));
        if (eg != 4'b0000) q.push_back('{e: edgeNo + 1, g: eg, d: lfsr_num});
        @(posedge clk);
        #1;
    endtask

    task automatic serve(input logic [3:0] r, input logic [3:0] eg);
        step(r, eg, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [3:0] seqB [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [3:0] seqC [4] = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};
`ifdef LFSR_SHARE_ZERO_GUARD_EN
    localparam logic [3:0] ZERO_GNT  = 4'b0000;
    localparam logic [3:0] AFTER_GNT = 4'b0100;
`else
    localparam logic [3:0] ZERO_GNT  = 4'b0001;
    localparam logic [3:0] AFTER_GNT = 4'b0010;
`endif

    initial begin
        reset = 1'b1; req = 4'b0; reseed_req = 1'b0; reseed_seed = 32'h0; lfsr_num = 32'h1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", {28'h0, gnt}, 32'h0);
        chk("rst_data", data, 32'h0);
        chk("rst_valid", {31'h0, data_valid}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h1);
        chk("rst_write", {31'h0, lfsr_write}, 32'h1);
        chk("rst_seed", lfsr_seed, DEF_SEED);
        chk("rst_zero_err", {31'h0, zero_err}, 32'h0);
        reset = 1'b0;

        // Seed, warm-up, first grant at edge 9
        serve(4'b0001, 4'b0000);
        chk("write_one_cycle", {31'h0, lfsr_write}, 32'h0);
        repeat (7) serve(4'b0001, 4'b0000);
        chk("busy_warmup_end", {31'h0, busy}, 32'h1);
        serve(4'b0001, 4'b0001);
        chk("busy_low_first_grant", {31'h0, busy}, 32'h0);

        for (int i = 0; i < 5; i++) serve(4'b1111, seqB[i]);
        for (int i = 0; i < 4; i++) serve(4'b1010, seqC[i]);
        serve(4'b0000, 4'b0000);

        // Reseed with zero seed during a burst
        serve(4'b1111, 4'b0100);
        step(4'b1111, 4'b0000, 1'b1, 32'h0, 1'b0);
        chk("reseed0_seed", lfsr_seed, DEF_SEED);
        chk("reseed0_write", {31'h0, lfsr_write}, 32'h1);
        chk("reseed0_busy", {31'h0, busy}, 32'h1);
        serve(4'b1111, 4'b0000);
        chk("reseed0_write_off", {31'h0, lfsr_write}, 32'h0);
        repeat (7) serve(4'b1111, 4'b0000);
        chk("reseed0_busy_end", {31'h0, busy}, 32'h1);
        serve(4'b1111, 4'b1000);
        chk("reseed0_resume", {31'h0, busy}, 32'h0);

        // Reseed with explicit seed
        serve(4'b1111, 4'b0001);
        step(4'b1111, 4'b0000, 1'b1, 32'hDEAD_BEEF, 1'b0);
        chk("reseedDB_seed", lfsr_seed, 32'hDEAD_BEEF);
        chk("reseedDB_write", {31'h0, lfsr_write}, 32'h1);
        repeat (8) serve(4'b1111, 4'b0000);
        serve(4'b1111, 4'b0010);
        chk("reseedDB_seed_hold", lfsr_seed, 32'hDEAD_BEEF);
        chk("reseedDB_write_off", {31'h0, lfsr_write}, 32'h0);

        // All-zero LFSR word in SERVE
        step(4'b0001, ZERO_GNT, 1'b0, 32'h0, 1'b1);
`ifdef LFSR_SHARE_ZERO_GUARD_EN
        chk("zero_err_set", {31'h0, zero_err}, 32'h1);
        chk("zero_seed", lfsr_seed, DEF_SEED);
        chk("zero_busy", {31'h0, busy}, 32'h1);
`else
        chk("zero_err_tied", {31'h0, zero_err}, 32'h0);
        chk("zero_busy", {31'h0, busy}, 32'h0);
`endif
        repeat (9) serve(4'b0000, 4'b0000);
        chk("idle_busy", {31'h0, busy}, 32'h0);
`ifdef LFSR_SHARE_ZERO_GUARD_EN
        chk("zero_err_sticky", {31'h0, zero_err}, 32'h1);
`endif

        // Reset mid-burst
        serve(4'b1111, AFTER_GNT);
        reset = 1'b1;
        serve(4'b1111, 4'b0000);
        chk("midrst_data", data, 32'h0);
        chk("midrst_busy", {31'h0, busy}, 32'h1);
        chk("midrst_write", {31'h0, lfsr_write}, 32'h1);
        chk("midrst_seed", lfsr_seed, DEF_SEED);
        chk("midrst_zero_err", {31'h0, zero_err}, 32'h0);
        reset = 1'b0;
        repeat (8) serve(4'b0110, 4'b0000);
        serve(4'b0110, 4'b0010);
        serve(4'b0000, 4'b0000);

        #3;
        chk("scoreboard_empty", 32'(q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lfsr_share_ctrl.md
# lfsr_share_ctrl

Sequencer and round-robin arbiter that owns one external 32-bit seeded LFSR (ports numout/seed/write) and shares its output stream among NREQ consumers in the random-normal generator, e.g. the per-lane sum-of-uniforms accumulators. It loads the seed after reset or on request, discards a warm-up run so seed bits never reach consumers, then hands out one fresh LFSR word per clock to one granted requester.

## Interface
- NREQ, 4, number of requesters (2..16)
- WIDTH, 32, LFSR word width
- SEED, 32'h1232_4a6f, default seed; must be nonzero
- WARMUP, 8, LFSR steps discarded after every seed load (1..255)

- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request level; held until granted
- gnt  out  NREQ  one-hot grant, registered, one cycle per grant
- data  out  WIDTH  LFSR word for the granted requester
- data_valid  out  1  high in the same cycle as any gnt bit
- reseed_req  in  1  single-cycle reseed strobe
- reseed_seed  in  WIDTH  seed sampled with reseed_req
- busy  out  1  high in SEED and WARMUP
- lfsr_num  in  WIDTH  LFSR numout
- lfsr_seed  out  WIDTH  LFSR seed
- lfsr_write  out  1  LFSR write (synchronous load)
- zero_err  out  1  sticky all-zero detect (ZERO_GUARD only; else tied 0)

## Operation
- States: SEED, WARMUP, SERVE.
- SEED (1 cycle): lfsr_write=1, lfsr_seed=loaded seed; next WARMUP, counter=WARMUP.
- WARMUP: lfsr_write=0; counter decrements each cycle; on reaching 1 → SERVE. No grants.
- SERVE: each cycle, if any req bit set, grant the first set bit searching upward from (last_grant+1) mod NREQ; register gnt, data=lfsr_num, data_valid=1; update last_grant. No req → gnt=0, data_valid=0, data holds.
- A requester seeing gnt at edge N must drop or re-present req so that req at edge N+1 reflects its next demand; a held req is granted again at its next round-robin turn.
- reseed_req (any state): latch seed = reseed_seed, or SEED if reseed_seed==0; next state SEED. Takes priority over pending req that cycle; no grant issued.
- lfsr_seed holds last loaded seed outside SEED; lfsr_write=1 only in SEED.

## Timing
- Reset values: gnt=0, data=0, data_valid=0, busy=1, lfsr_write=1, lfsr_seed=SEED, zero_err=0, last_grant=NREQ-1 (so requester 0 wins first), state=SEED.
- First grant possible at edge 1+WARMUP after reset deasserts; busy falls on the same edge.
- Grant latency: req high at edge N (SERVE) → gnt/data_valid high after edge N.
- Throughput: one grant per cycle; every requester holding req is granted within NREQ cycles.
- Reseed: strobe at edge N → SEED after N, busy=1, gnt=0; SERVE resumes after edge N+1+WARMUP.
- Reseed in SEED/WARMUP restarts SEED with the new seed.
- Reset mid-operation overrides all; in-flight grant dropped, last_grant restored.

## Configuration
- LFSR_SHARE_ZERO_GUARD_EN defined: in SERVE, lfsr_num==0 suppresses that cycle's grant, sets zero_err (cleared only by reset), forces transition to SEED with SEED.
- Undefined: no check; zero word granted like any other; zero_err tied 0.

## Test plan
- Reset, hold reset 3 cycles then release, req=4'b0001: lfsr_write=1 for exactly one cycle with lfsr_seed=32'h1232_4a6f; first gnt=4'b0001 after edge 9 (WARMUP=8); busy low from edge 9.
- req=4'b1111 held in SERVE: gnt sequence 0001,0010,0100,1000,0001; data_valid every cycle; data matches lfsr_num sampled each edge.
- req=4'b1010 held: gnt alternates 0010/1000; requester idle bits never granted.
- reseed_req with reseed_seed=0 during a grant burst: no grant that cycle, lfsr_seed=SEED in SEED cycle, grants resume after WARMUP+1; repeat with 32'hDEAD_BEEF and check lfsr_seed.
- Reset asserted mid-burst: next cycle gnt=0, data=0, busy=1, state SEED; first post-reset grant goes to lowest set req bit.
- With LFSR_SHARE_ZERO_GUARD_EN, bench forces lfsr_num=0 in SERVE: no grant, zero_err=1 and sticky, SEED entered with default seed; without macro, gnt issued with data=0.
